// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes the keyboard clock/data, deframes
// 11-bit frames with start/parity/stop checks and queues bytes in a FIFO.
module ps2_keyboard #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [2:0]       ps2_clk_sync_q, ps2_clk_sync_d;
  logic [1:0]       ps2_data_sync_q, ps2_data_sync_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             frame_ok_q, frame_ok_d;
  logic [7:0]       frame_byte_q, frame_byte_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             ready_q, ready_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic        fall;
  logic        data_s;
  logic [10:0] frame;
  logic        pop;
  logic        push;
  logic        full;

  assign fall   = ps2_clk_sync_q[2] & ~ps2_clk_sync_q[1];
  assign data_s = ps2_data_sync_q[1];
  // The shift register holds the first ten samples; the eleventh is the live bit.
  assign frame  = {data_s, shift_q};

  always_comb begin
    ps2_clk_sync_d  = {ps2_clk_sync_q[1:0], ps2_clk};
    ps2_data_sync_d = {ps2_data_sync_q[0], ps2_data};
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    to_cnt_d        = to_cnt_q;
    frame_ok_d      = 1'b0;
    frame_byte_d    = frame_byte_q;
    if (fall) begin
      shift_d  = {data_s, shift_q[9:1]};
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (!frame[0] && frame[10] && (^frame[9:1])) begin
          frame_ok_d   = 1'b1;
          frame_byte_d = frame[8:1];
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  assign pop  = ~nextdata_n & ready_q;
  assign full = (count_q == FULL_COUNT);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push = frame_ok_q & (~full | pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    count_d    = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    overflow_d = overflow_q | (frame_ok_q & full & ~pop);
    ready_d    = (count_d != '0);
    data_d     = 8'h00;
    if (count_d != '0) begin
      if (push && (count_q == (PTR_W + 1)'(pop)))
        data_d = frame_byte_q;
      else
        data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2_clk_sync_q  <= 3'b111;
      ps2_data_sync_q <= 2'b11;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      to_cnt_q        <= '0;
      frame_ok_q      <= 1'b0;
      frame_byte_q    <= 8'h00;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      overflow_q      <= 1'b0;
      ready_q         <= 1'b0;
      data_q          <= 8'h00;
    end else begin
      ps2_clk_sync_q  <= ps2_clk_sync_d;
      ps2_data_sync_q <= ps2_data_sync_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      to_cnt_q        <= to_cnt_d;
      frame_ok_q      <= frame_ok_d;
      frame_byte_q    <= frame_byte_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      overflow_q      <= overflow_d;
      ready_q         <= ready_d;
      data_q          <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= frame_byte_q;
  end

  assign data     = data_q;
  assign ready    = ready_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus randomized
// frames compared against a queue-based model of the received byte stream.
module tb_ps2_keyboard;

  localparam int DEPTH = 8;
  localparam int TO    = 200;
  localparam int HALF  = 20;

  logic       clk        = 1'b0;
  logic       clrn       = 1'b0;
  logic       ps2_clk    = 1'b1;
  logic       ps2_data   = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] model_q[$];
  logic       model_ovf = 1'b0;

  ps2_keyboard #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all outputs with the model; sync=1 samples on the falling clock edge.
  task automatic checkOutput(input string tag, input bit sync);
    logic [7:0] exp_data;
    logic       exp_ready;
    if (sync) @(negedge clk);
    exp_ready = (model_q.size() != 0);
    exp_data  = exp_ready ? model_q[0] : 8'h00;
    check({tag, "/ready"},    {7'b0, ready},    {7'b0, exp_ready});
    check({tag, "/data"},     data,             exp_data);
    check({tag, "/overflow"}, {7'b0, overflow}, {7'b0, model_ovf});
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] b, input bit bad_par,
                                            input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic sendBits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      waitClk(HALF / 2);
      ps2_clk = 1'b0;
      waitClk(HALF);
      ps2_clk = 1'b1;
      waitClk(HALF / 2);
    end
  endtask

  // Send a full frame and apply the protocol rules to the model.
  task automatic applyStimulus(input logic [10:0] f);
    sendBits(f, 11);
    waitClk(4);
    if (f[0] == 1'b0 && f[10] == 1'b1 && (^f[9:1]) == 1'b1) begin
      if (model_q.size() < DEPTH) model_q.push_back(f[8:1]);
      else model_ovf = 1'b1;
    end
  endtask

  task automatic popN(input int n);
    nextdata_n = 1'b0;
    waitClk(n);
    nextdata_n = 1'b1;
    for (int i = 0; i < n; i++)
      if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  b;
    int          mode;

    waitClk(3);
    checkOutput("reset", 1'b1);
    clrn = 1'b1;
    waitClk(3);

    $display("[TB] single frame and pop");
    applyStimulus(makeFrame(8'h1C, 0, 0));
    checkOutput("frame1C", 1'b1);
    popN(1);
    checkOutput("pop1C", 1'b1);

    $display("[TB] two frames in order");
    applyStimulus(makeFrame(8'hF0, 0, 0));
    applyStimulus(makeFrame(8'h1C, 0, 0));
    checkOutput("headF0", 1'b1);
    popN(1);
    checkOutput("head1C", 1'b1);
    popN(1);
    checkOutput("drained", 1'b1);

    $display("[TB] bad parity / bad stop");
    applyStimulus(makeFrame(8'h1C, 1, 0));
    checkOutput("badpar", 1'b1);
    applyStimulus(makeFrame(8'h1C, 0, 1));
    checkOutput("badstop", 1'b1);
    applyStimulus(makeFrame(8'h32, 0, 0));
    checkOutput("after_bad", 1'b1);
    popN(1);
    popN(1);
    checkOutput("pop_empty", 1'b1);

    $display("[TB] fill and overflow");
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(makeFrame(8'(i), 0, 0));
      if (i >= 8) checkOutput($sformatf("fill%0d", i), 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      popN(1);
      checkOutput($sformatf("drain%0d", i), 1'b1);
    end

    $display("[TB] partial frame timeout");
    sendBits(makeFrame(8'hAA, 0, 0), 5);
    waitClk(TO + 50);
    checkOutput("timeout_idle", 1'b1);
    applyStimulus(makeFrame(8'h45, 0, 0));
    checkOutput("frame45", 1'b1);

    $display("[TB] async reset mid-frame");
    applyStimulus(makeFrame(8'h11, 0, 0));
    applyStimulus(makeFrame(8'h22, 0, 0));
    sendBits(makeFrame(8'h33, 0, 0), 4);
    ps2_clk = 1'b0;
    @(posedge clk);
    #3 clrn = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    #1 checkOutput("async_reset", 1'b0);
    ps2_clk = 1'b1;
    waitClk(3);
    clrn = 1'b1;
    waitClk(3);
    applyStimulus(makeFrame(8'h77, 0, 0));
    checkOutput("post_reset", 1'b1);

    $display("[TB] randomized frames");
    for (int k = 0; k < 40; k++) begin
      b    = 8'($urandom);
      mode = $urandom_range(0, 3);
      f    = makeFrame(b, 0, 0);
      if (mode == 0) f[$urandom_range(0, 10)] ^= 1'b1;
      applyStimulus(f);
      checkOutput($sformatf("rnd%0d", k), 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        popN($urandom_range(1, 3));
        checkOutput($sformatf("rndpop%0d", k), 1'b1);
      end
    end
    popN(DEPTH + 2);
    checkOutput("final_drain", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
